// File: rtl/hv_pwm_seq.sv
// HV supply sequencer: power-on delay, HV enable, and N slew-limited PWM-DAC
// channels with runtime-writable target duty and latched fault shutdown.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | HV off, PWM low, waiting for i_enable
//  DELAY   | counting HVEN_DELAY clocks before HV enable
//  RAMP    | HV on, cur duties slewing toward targets
//  ON      | HV on, all cur duties at target (still tracks new writes)
//  FAULT   | HV off, PWM low, latched until i_fault_clr with fault gone
module hv_pwm_seq #(
  parameter int CH_NUM       = 2,
  parameter int PWM_W        = 11,
  parameter int PWM_PERIOD   = 1024,
  parameter int HVEN_DELAY   = 100_000_000,
  parameter int RAMP_STEP    = 1,
  parameter int DUTY_DEFAULT = 819
) (
  input  logic              i_clk_50m,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_fault,
  input  logic              i_fault_clr,
  input  logic              i_duty_wr,
  input  logic [2:0]        i_duty_ch,
  input  logic [PWM_W-1:0]  i_duty_data,
  output logic              o_hv_en,
  output logic [CH_NUM-1:0] o_da_pwm,
  output logic              o_ramp_done,
  output logic              o_fault_latch,
  output logic [1:0]        o_state
);

  localparam logic [PWM_W-1:0] PERIOD   = PWM_W'(PWM_PERIOD);
  localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'(PWM_PERIOD - 1);
  localparam logic [PWM_W-1:0] STEP     = PWM_W'(RAMP_STEP);
  localparam int               DEF_CLMP = (DUTY_DEFAULT > PWM_PERIOD) ? PWM_PERIOD : DUTY_DEFAULT;
  localparam logic [PWM_W-1:0] DEF_DUTY = PWM_W'(DEF_CLMP);
  localparam logic [31:0]      DLY_LAST = 32'(HVEN_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_RAMP,
    S_ON,
    S_FAULT
  } state_t;

  state_t           state;
  logic             fault_m;
  logic             fault_s;
  logic [PWM_W-1:0] pcnt;
  logic             wrap;
  logic [31:0]      dly_cnt;
  logic [PWM_W-1:0] cur [CH_NUM];
  logic [PWM_W-1:0] tgt [CH_NUM];
  logic             run;
  logic             all_eq;

  assign wrap = (pcnt == CNT_LAST);
  assign run  = (state == S_RAMP) || (state == S_ON);

  // Reduce per-channel "cur reached target" into one flag.
  always_comb begin
    all_eq = 1'b1;
    for (int c = 0; c < CH_NUM; c++) begin
      if (cur[c] != tgt[c]) all_eq = 1'b0;
    end
  end

  // Externally reported state; FAULT reads as IDLE.
  always_comb begin
    case (state)
      S_DELAY: o_state = 2'd1;
      S_RAMP:  o_state = 2'd2;
      S_ON:    o_state = 2'd3;
      default: o_state = 2'd0;
    endcase
  end

  // Two-flop synchronizer for the asynchronous fault input.
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fault_m <= 1'b0;
      fault_s <= 1'b0;
    end else begin
      fault_m <= i_fault;
      fault_s <= fault_m;
    end
  end

  // Free-running PWM period counter, independent of FSM state.
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) pcnt <= '0;
    else if (wrap) pcnt <= '0;
    else pcnt <= pcnt + 1'b1;
  end

  // Target duty register file; out-of-range channel writes fall through the loop unmatched.
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < CH_NUM; c++) tgt[c] <= DEF_DUTY;
    end else if (i_duty_wr) begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (i_duty_ch == 3'(c)) tgt[c] <= (i_duty_data > PERIOD) ? PERIOD : i_duty_data;
      end
    end
  end

  // Slew cur toward target once per period; held at 0 whenever HV is not running.
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < CH_NUM; c++) cur[c] <= '0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (!run) begin
          cur[c] <= '0;
        end else if (wrap) begin
          if (cur[c] < tgt[c]) begin
            cur[c] <= ((tgt[c] - cur[c]) > STEP) ? cur[c] + STEP : tgt[c];
          end else if (cur[c] > tgt[c]) begin
            cur[c] <= ((cur[c] - tgt[c]) > STEP) ? cur[c] - STEP : tgt[c];
          end
        end
      end
    end
  end

  // Registered PWM compare; cur == PERIOD yields a constant-high output.
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_da_pwm <= '0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) o_da_pwm[c] <= run && (pcnt < cur[c]);
    end
  end

  // Sequencing FSM with registered HV enable, ramp-done and fault latch.
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      dly_cnt       <= '0;
      o_hv_en       <= 1'b0;
      o_ramp_done   <= 1'b0;
      o_fault_latch <= 1'b0;
    end else if (fault_s) begin
      state         <= S_FAULT;
      dly_cnt       <= '0;
      o_hv_en       <= 1'b0;
      o_ramp_done   <= 1'b0;
      o_fault_latch <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          o_hv_en     <= 1'b0;
          o_ramp_done <= 1'b0;
          dly_cnt     <= '0;
          if (i_enable) state <= S_DELAY;
        end
        S_DELAY: begin
          if (!i_enable) begin
            state   <= S_IDLE;
            dly_cnt <= '0;
          end else if (dly_cnt == DLY_LAST) begin
            state   <= S_RAMP;
            o_hv_en <= 1'b1;
          end else begin
            dly_cnt <= dly_cnt + 32'd1;
          end
        end
        S_RAMP, S_ON: begin
          if (!i_enable) begin
            state       <= S_IDLE;
            o_hv_en     <= 1'b0;
            o_ramp_done <= 1'b0;
          end else begin
            o_ramp_done <= all_eq;
            if (state == S_RAMP && wrap && all_eq) state <= S_ON;
          end
        end
        S_FAULT: begin
          o_hv_en     <= 1'b0;
          o_ramp_done <= 1'b0;
          if (i_fault_clr) begin
            state         <= S_IDLE;
            o_fault_latch <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
